// File: rtl/demux_1_to_4_if.sv
// Bundle of the producer-side and consumer-side handshake signals for the 1-to-4 word distributor.
// The slave modport is the distributor's view; the master modport is the view of the surrounding logic.
interface demux_1_to_4_if #(
  parameter int WORD_WIDTH = 16
) ();

  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            sel;
  logic                  rr_en;
  logic [1:0]            cur_sel;
  logic [WORD_WIDTH-1:0] out1;
  logic [WORD_WIDTH-1:0] out2;
  logic [WORD_WIDTH-1:0] out3;
  logic [WORD_WIDTH-1:0] out4;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  sel,
    input  rr_en,
    output cur_sel,
    output out1,
    output out2,
    output out3,
    output out4,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output sel,
    output rr_en,
    input  cur_sel,
    input  out1,
    input  out2,
    input  out3,
    input  out4,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/demux_1_to_4.sv
// Registered 1-to-4 word distributor: one producer handshake fans out into four one-entry lanes,
// steered by an explicit lane select or by an internal round-robin pointer.
module demux_1_to_4 #(
  parameter int WORD_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  demux_1_to_4_if.slave     bus
);

  logic [WORD_WIDTH-1:0] r_laneData [4];
  logic [3:0]            r_laneValid;
  logic [1:0]            r_rrPtr;

  logic [1:0]            w_dest;
  logic                  w_destFree;
  logic                  w_inReady;
  logic                  w_accept;
  logic [3:0]            w_write;
  logic [3:0]            w_drain;

  assign w_dest = bus.rr_en ? r_rrPtr : bus.sel;

  // The destination lane can take a word if it is empty or its consumer empties it this same cycle.
  assign w_destFree = ~r_laneValid[w_dest] | bus.out_ready[w_dest];
  assign w_inReady  = ~rst & w_destFree;
  assign w_accept   = bus.in_valid & w_inReady;

  always_comb begin
    w_write = 4'b0000;
    w_drain = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_write[i] = w_accept & (w_dest == 2'(i));
      w_drain[i] = r_laneValid[i] & bus.out_ready[i];
    end
  end

  // A write wins over a drain on the same lane so back-to-back traffic keeps the lane full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_laneValid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_laneData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_write[i]) begin
          r_laneData[i]  <= bus.in_data;
          r_laneValid[i] <= 1'b1;
        end else if (w_drain[i]) begin
          r_laneValid[i] <= 1'b0;
        end
      end
    end
  end

  // The pointer only moves on round-robin accepts and survives mode switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr <= 2'd0;
    end else if (w_accept && bus.rr_en) begin
      r_rrPtr <= r_rrPtr + 2'd1;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.cur_sel   = w_dest;
  assign bus.out1      = r_laneData[0];
  assign bus.out2      = r_laneData[1];
  assign bus.out3      = r_laneData[2];
  assign bus.out4      = r_laneData[3];
  assign bus.out_valid = r_laneValid;

endmodule

// File: tb/tb_demux_1_to_4.sv
// Directed-vector bench for demux_1_to_4: inputs change on the falling edge, outputs are checked
// either just after the drive (combinational) or one falling edge after the rising edge (registered).
module tb_demux_1_to_4;

  logic clk;
  logic rst;
  int   vectorCount;
  int   missCount;

  demux_1_to_4_if #(.WORD_WIDTH(16)) bus ();

  demux_1_to_4 #(.WORD_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obsLane [4];
  assign obsLane[0] = bus.out1;
  assign obsLane[1] = bus.out2;
  assign obsLane[2] = bus.out3;
  assign obsLane[3] = bus.out4;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [1:0] laneSel,
                               input logic rrEn, input logic [3:0] outReady);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.sel       = laneSel;
    bus.rr_en     = rrEn;
    bus.out_ready = outReady;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] rrWords [6];
  logic [15:0] explicitWords [4];

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rrWords       = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    explicitWords = '{16'h0F50, 16'hFF50, 16'hAAAA, 16'h7FFF};

    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 2'd2, 1'b0, 4'b0000);
    tick();
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("reset cur_sel sel", 32'(bus.cur_sel), 32'h2);
    checkOutput("reset out1", 32'(bus.out1), 32'h0);
    checkOutput("reset out4", 32'(bus.out4), 32'h0);
    applyStimulus(1'b1, 16'hBEEF, 2'd2, 1'b1, 4'b0000);
    checkOutput("reset cur_sel rr", 32'(bus.cur_sel), 32'h0);
    checkOutput("reset in_ready valid", 32'(bus.in_ready), 32'h0);
    tick();
    checkOutput("reset no accept", 32'(bus.out_valid), 32'h0);

    // explicit routing
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, explicitWords[i], 2'(i), 1'b0, 4'b0000);
      checkOutput($sformatf("explicit in_ready %0d", i), 32'(bus.in_ready), 32'h1);
      checkOutput($sformatf("explicit cur_sel %0d", i), 32'(bus.cur_sel), 32'(i));
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 4'b0000);
    checkOutput("explicit out1", 32'(bus.out1), 32'h0F50);
    checkOutput("explicit out2", 32'(bus.out2), 32'hFF50);
    checkOutput("explicit out3", 32'(bus.out3), 32'hAAAA);
    checkOutput("explicit out4", 32'(bus.out4), 32'h7FFF);
    checkOutput("explicit out_valid", 32'(bus.out_valid), 32'hF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h9999, 2'(i), 1'b0, 4'b0000);
      checkOutput($sformatf("full in_ready %0d", i), 32'(bus.in_ready), 32'h0);
    end

    // drain without refill on lane 1
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 4'b0001);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 4'b0000);
    checkOutput("drain out_valid", 32'(bus.out_valid), 32'hE);
    checkOutput("drain out1 held", 32'(bus.out1), 32'h0F50);

    // back-pressure on lane 3
    applyStimulus(1'b1, 16'h1234, 2'd2, 1'b0, 4'b0000);
    checkOutput("bp in_ready low", 32'(bus.in_ready), 32'h0);
    tick();
    checkOutput("bp out3 kept", 32'(bus.out3), 32'hAAAA);
    checkOutput("bp out_valid kept", 32'(bus.out_valid), 32'hE);
    applyStimulus(1'b1, 16'h1234, 2'd2, 1'b0, 4'b0100);
    checkOutput("bp in_ready high", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'd2, 1'b0, 4'b0000);
    checkOutput("bp out3 replaced", 32'(bus.out3), 32'h1234);
    checkOutput("bp out_valid stays", 32'(bus.out_valid), 32'hE);

    // clean start for round-robin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2 out_valid", 32'(bus.out_valid), 32'h0);

    // round-robin wrap with every consumer ready
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, rrWords[i], 2'd0, 1'b1, 4'b1111);
      checkOutput($sformatf("rr cur_sel %0d", i), 32'(bus.cur_sel), 32'(i % 4));
      checkOutput($sformatf("rr in_ready %0d", i), 32'(bus.in_ready), 32'h1);
      tick();
      checkOutput($sformatf("rr lane data %0d", i), 32'(obsLane[i % 4]), 32'(rrWords[i]));
      checkOutput($sformatf("rr out_valid %0d", i), 32'(bus.out_valid), 32'(4'b0001 << (i % 4)));
    end

    // mode switch: pointer sits at 2
    applyStimulus(1'b1, 16'h00AA, 2'd0, 1'b0, 4'b1111);
    checkOutput("mode sel cur_sel", 32'(bus.cur_sel), 32'h0);
    tick();
    checkOutput("mode sel out1", 32'(bus.out1), 32'h00AA);
    applyStimulus(1'b1, 16'h00BB, 2'd0, 1'b1, 4'b1111);
    checkOutput("mode rr ptr held", 32'(bus.cur_sel), 32'h2);
    tick();
    checkOutput("mode rr out3", 32'(bus.out3), 32'h00BB);
    checkOutput("mode rr out_valid", 32'(bus.out_valid), 32'h4);

    // build lanes 2 and 4 full with pointer at 3 (lane 3 drains first)
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 4'b1111);
    tick();
    applyStimulus(1'b1, 16'h2222, 2'd1, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b1, 16'h4444, 2'd3, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 4'b0000);
    checkOutput("pre-reset out_valid", 32'(bus.out_valid), 32'hA);
    checkOutput("pre-reset rr ptr", 32'(bus.cur_sel), 32'h3);

    // reset mid-stream with a word presented
    rst = 1'b1;
    applyStimulus(1'b1, 16'hDEAD, 2'd0, 1'b1, 4'b0000);
    checkOutput("midrst in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 4'b0000);
    checkOutput("midrst out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst out2", 32'(bus.out2), 32'h0);
    checkOutput("midrst out4", 32'(bus.out4), 32'h0);
    checkOutput("midrst out1", 32'(bus.out1), 32'h0);
    checkOutput("midrst rr ptr", 32'(bus.cur_sel), 32'h0);
    applyStimulus(1'b1, 16'h5555, 2'd3, 1'b1, 4'b0000);
    checkOutput("postrst in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 4'b0000);
    checkOutput("postrst out1", 32'(bus.out1), 32'h5555);
    checkOutput("postrst out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("postrst rr ptr", 32'(bus.cur_sel), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
